debug_pipeline_sequencer: RTL and testbench
===========================================

DEBUG_PIPELINE_SEQUENCER -- requirements
Module: debug_pipeline_sequencer

Interface
REQ-001 SHALL have parameter CANT_REGISTROS, default 32, number of architectural registers dumped.
REQ-002 SHALL have parameter CANT_BITS_REGISTROS, default 32, register data width.
REQ-003 SHALL have parameter CANT_BITS_CYCLES, default 16, width of the pipeline cycle counter.
REQ-004 SHALL have port i_clock, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port i_soft_reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_cmd_valid, input, 1, command offered.
REQ-007 SHALL have port i_cmd, input, 2, command: 00 RUN, 01 STEP, 10 DUMP, 11 ABORT.
REQ-008 SHALL have port o_cmd_ready, output, 1, command accepted when i_cmd_valid & o_cmd_ready.
REQ-009 SHALL have port i_halt_detected, input, 1, halt instruction retired.
REQ-010 SHALL have port o_enable_pipeline, output, 1, advance all pipeline registers this cycle.
REQ-011 SHALL have port o_enable_etapa, output, 1, stage enable, including register file debug read.
REQ-012 SHALL have port o_reg_read_addr, output, clog2(CANT_REGISTROS), register file debug read address.
REQ-013 SHALL have port i_reg_data, input, CANT_BITS_REGISTROS, register file debug read data.
REQ-014 SHALL have ports o_dump_valid (output, 1), o_dump_data (output, CANT_BITS_REGISTROS) and i_dump_ready (input, 1): dump stream.
REQ-015 SHALL have ports o_halted (output, 1, sticky halt flag) and o_cycle_count (output, CANT_BITS_CYCLES, enabled-cycle count).

Function
REQ-016 SHALL implement states IDLE, RUN, STEP, HALTED, DUMP_ADDR and DUMP_WAIT.
REQ-017 SHALL assert o_cmd_ready in IDLE, HALTED and RUN only.
REQ-018 IDLE SHALL go to RUN on RUN, STEP on STEP and DUMP_ADDR on DUMP; ABORT is accepted with no effect.
REQ-019 RUN SHALL drive o_enable_pipeline=1 every cycle.
REQ-020 RUN SHALL go to IDLE on an accepted ABORT; other commands are accepted and dropped.
REQ-021 STEP SHALL drive o_enable_pipeline=1 for exactly one cycle, then go to IDLE.
REQ-022 i_halt_detected sampled high in RUN or STEP SHALL set o_halted and leave for HALTED, or DUMP_ADDR per REQ-039.
REQ-023 Halt and ABORT in the same cycle SHALL resolve as halt.
REQ-024 HALTED SHALL go to DUMP_ADDR on DUMP; RUN and STEP are accepted and ignored; ABORT returns to IDLE and clears o_halted.
REQ-025 DUMP_ADDR SHALL present the index counter on o_reg_read_addr and go to DUMP_WAIT next cycle.
REQ-026 DUMP_WAIT SHALL capture i_reg_data into o_dump_data on entry and assert o_dump_valid.
REQ-027 o_dump_valid and o_dump_data SHALL stay stable until i_dump_ready.
REQ-028 On transfer, index < CANT_REGISTROS-1 SHALL increment the index and return to DUMP_ADDR.
REQ-029 On transfer, the last index SHALL clear the index and return to HALTED if o_halted, else IDLE.
REQ-030 Register read latency SHALL be one cycle; the dump SHALL take at least 2*CANT_REGISTROS cycles.
REQ-031 o_enable_pipeline SHALL be 0 in IDLE, HALTED, DUMP_ADDR and DUMP_WAIT; the pipeline never advances during a dump.
REQ-032 o_enable_etapa SHALL be 1 in every state except IDLE.
REQ-033 o_cycle_count SHALL increment on each cycle with o_enable_pipeline=1, saturate at all-ones, and clear only on reset.

Reset
REQ-034 Reset SHALL act asynchronously on assertion and release synchronously to i_clock.
REQ-035 Reset SHALL force state IDLE and dump index 0.
REQ-036 Reset SHALL drive all outputs to 0: o_enable_pipeline, o_enable_etapa, o_dump_valid, o_dump_data, o_halted, o_cycle_count, o_reg_read_addr.
REQ-037 Reset during a dump SHALL abort it with no further o_dump_valid.

Configuration
REQ-038 Macro DEBUG_SEQ_AUTO_DUMP_EN SHALL select the halt behaviour.
REQ-039 With DEBUG_SEQ_AUTO_DUMP_EN defined, a halt in RUN/STEP SHALL go directly to DUMP_ADDR with o_halted=1.
REQ-040 Without DEBUG_SEQ_AUTO_DUMP_EN, a halt SHALL go to HALTED and wait for DUMP.

Structure
REQ-041 Package debug_seq_pkg SHALL hold the command encodings, the state enum and default widths.
REQ-042 Sub-module debug_reg_dump SHALL hold the index counter and the valid/ready output holding register; the top holds the FSM and cycle counter.

Verification
REQ-043 Reset, then STEP -> o_enable_pipeline high exactly 1 cycle; o_cycle_count=1; state IDLE.
REQ-044 RUN, halt on enabled cycle 10 -> o_cycle_count=10; o_halted=1; o_enable_pipeline low from the next cycle.
REQ-045 DUMP with regs loaded reg[i]=i*4 and i_dump_ready stalled 3 cycles on beat 5 -> 32 beats 0,4,...,124 in order; beat 5 held stable.
REQ-046 RUN, then ABORT and halt in the same cycle -> o_halted=1; state HALTED (REQ-040 build) or DUMP_ADDR (REQ-039 build).
REQ-047 Reset asserted during beat 7 of a dump -> outputs 0 immediately; a later DUMP restarts at address 0.
REQ-048 RUN for 70000 cycles with 16-bit counter -> o_cycle_count=16'hFFFF, no wrap.

Source files
------------

// File: rtl/debug_seq_pkg.sv
// Shared command encodings, sequencer state enum and default widths for the
// debug pipeline sequencer and its register-dump engine.
package debug_seq_pkg;

  localparam int DEF_CANT_REGISTROS      = 32;
  localparam int DEF_CANT_BITS_REGISTROS = 32;
  localparam int DEF_CANT_BITS_CYCLES    = 16;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_DUMP  = 2'b10,
    CMD_ABORT = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP      = 3'd2,
    ST_HALTED    = 3'd3,
    ST_DUMP_ADDR = 3'd4,
    ST_DUMP_WAIT = 3'd5
  } state_e;

  // A single-register file still needs a one-bit address port.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_reg_dump.sv
// Register-dump engine: walks the debug read index and holds each captured
// register value on a valid/ready stream until it is accepted.
module debug_reg_dump
  import debug_seq_pkg::*;
#(
  parameter int N_REGS = DEF_CANT_REGISTROS,
  parameter int DATA_W = DEF_CANT_BITS_REGISTROS,
  parameter int ADDR_W = addr_width(DEF_CANT_REGISTROS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              capture_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [ADDR_W-1:0] index_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              xfer_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] index_q, index_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              xfer_s, last_s;

  assign xfer_s = valid_q & ready_i;
  assign last_s = (index_q == ADDR_W'(N_REGS - 1));

  // Capture loads a beat; a completed transfer retires it and advances the index.
  always_comb begin
    index_d = index_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (capture_i) begin
      data_d  = reg_data_i;
      valid_d = 1'b1;
    end else if (xfer_s) begin
      valid_d = 1'b0;
      index_d = last_s ? {ADDR_W{1'b0}} : (index_q + ADDR_W'(1));
    end else begin
      index_d = index_q;
    end
  end

  // Beat holding register and index counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      index_q <= {ADDR_W{1'b0}};
      valid_q <= 1'b0;
      data_q  <= {DATA_W{1'b0}};
    end else begin
      index_q <= index_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign index_o = index_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign xfer_o  = xfer_s;
  assign last_o  = last_s;

endmodule

// File: rtl/debug_pipeline_sequencer.sv
// Debug sequencer: RUN/STEP/DUMP/ABORT control of the pipeline, halt capture,
// enabled-cycle counter. Define DEBUG_SEQ_AUTO_DUMP_EN to dump on halt.
module debug_pipeline_sequencer
  import debug_seq_pkg::*;
#(
  parameter int CANT_REGISTROS      = DEF_CANT_REGISTROS,
  parameter int CANT_BITS_REGISTROS = DEF_CANT_BITS_REGISTROS,
  parameter int CANT_BITS_CYCLES    = DEF_CANT_BITS_CYCLES
) (
  input  logic                                  i_clock,
  input  logic                                  i_soft_reset,
  input  logic                                  i_cmd_valid,
  input  logic [1:0]                            i_cmd,
  output logic                                  o_cmd_ready,
  input  logic                                  i_halt_detected,
  output logic                                  o_enable_pipeline,
  output logic                                  o_enable_etapa,
  output logic [addr_width(CANT_REGISTROS)-1:0] o_reg_read_addr,
  input  logic [CANT_BITS_REGISTROS-1:0]        i_reg_data,
  output logic                                  o_dump_valid,
  output logic [CANT_BITS_REGISTROS-1:0]        o_dump_data,
  input  logic                                  i_dump_ready,
  output logic                                  o_halted,
  output logic [CANT_BITS_CYCLES-1:0]           o_cycle_count
);

  localparam int ADDR_W = addr_width(CANT_REGISTROS);

`ifdef DEBUG_SEQ_AUTO_DUMP_EN
  localparam state_e HALT_DEST = ST_DUMP_ADDR;
`else
  localparam state_e HALT_DEST = ST_HALTED;
`endif

  state_e                      state_q, state_d;
  logic                        halted_q, halted_d;
  logic [CANT_BITS_CYCLES-1:0] cycles_q, cycles_d;

  logic cmd_ready_s, cmd_acc_s, en_pipe_s, etapa_s, capture_s;
  logic xfer_s, last_s, halt_now_s, abort_s;

  assign cmd_acc_s  = i_cmd_valid & cmd_ready_s;
  assign abort_s    = cmd_acc_s & (cmd_e'(i_cmd) == CMD_ABORT);
  assign halt_now_s = i_halt_detected & ((state_q == ST_RUN) | (state_q == ST_STEP));

  // State register.
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a halt outranks a simultaneous ABORT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc_s) begin
          case (cmd_e'(i_cmd))
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            CMD_DUMP: state_d = ST_DUMP_ADDR;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_now_s)   state_d = HALT_DEST;
        else if (abort_s) state_d = ST_IDLE;
        else              state_d = ST_RUN;
      end
      ST_STEP: begin
        if (halt_now_s) state_d = HALT_DEST;
        else            state_d = ST_IDLE;
      end
      ST_HALTED: begin
        if (cmd_acc_s && cmd_e'(i_cmd) == CMD_DUMP) state_d = ST_DUMP_ADDR;
        else if (abort_s)                            state_d = ST_IDLE;
        else                                         state_d = ST_HALTED;
      end
      ST_DUMP_ADDR: state_d = ST_DUMP_WAIT;
      ST_DUMP_WAIT: begin
        if (xfer_s && last_s)  state_d = halted_q ? ST_HALTED : ST_IDLE;
        else if (xfer_s)       state_d = ST_DUMP_ADDR;
        else                   state_d = ST_DUMP_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    cmd_ready_s = 1'b0;
    en_pipe_s   = 1'b0;
    etapa_s     = 1'b1;
    capture_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        etapa_s     = 1'b0;
      end
      ST_RUN: begin
        cmd_ready_s = 1'b1;
        en_pipe_s   = 1'b1;
      end
      ST_STEP:      en_pipe_s   = 1'b1;
      ST_HALTED:    cmd_ready_s = 1'b1;
      ST_DUMP_ADDR: capture_s   = 1'b1;
      ST_DUMP_WAIT: capture_s   = 1'b0;
      default:      etapa_s     = 1'b0;
    endcase
  end

  // Sticky halt flag and saturating enabled-cycle counter.
  always_comb begin
    halted_d = halted_q;
    cycles_d = cycles_q;
    if (halt_now_s) begin
      halted_d = 1'b1;
    end else if (abort_s && state_q == ST_HALTED) begin
      halted_d = 1'b0;
    end else begin
      halted_d = halted_q;
    end
    if (en_pipe_s && cycles_q != {CANT_BITS_CYCLES{1'b1}}) begin
      cycles_d = cycles_q + CANT_BITS_CYCLES'(1);
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Halt flag and cycle counter registers.
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      halted_q <= 1'b0;
      cycles_q <= {CANT_BITS_CYCLES{1'b0}};
    end else begin
      halted_q <= halted_d;
      cycles_q <= cycles_d;
    end
  end

  debug_reg_dump #(
    .N_REGS (CANT_REGISTROS),
    .DATA_W (CANT_BITS_REGISTROS),
    .ADDR_W (ADDR_W)
  ) u_dump (
    .clk_i      (i_clock),
    .rst_ni     (i_soft_reset),
    .capture_i  (capture_s),
    .ready_i    (i_dump_ready),
    .reg_data_i (i_reg_data),
    .index_o    (o_reg_read_addr),
    .valid_o    (o_dump_valid),
    .data_o     (o_dump_data),
    .xfer_o     (xfer_s),
    .last_o     (last_s)
  );

  assign o_cmd_ready       = cmd_ready_s;
  assign o_enable_pipeline = en_pipe_s;
  assign o_enable_etapa    = etapa_s;
  assign o_halted          = halted_q;
  assign o_cycle_count     = cycles_q;

endmodule

// File: tb/tb_debug_pipeline_sequencer.sv
// Directed bench for debug_pipeline_sequencer: step, run/halt, dump with
// back-pressure, abort/halt race, reset mid-dump and counter saturation.
module tb_debug_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        cmd_ready;
  logic        halt = 1'b0;
  logic        en_pipe;
  logic        etapa;
  logic [4:0]  addr;
  logic [31:0] reg_data;
  logic        dump_valid;
  logic [31:0] dump_data;
  logic        dump_ready = 1'b0;
  logic        halted;
  logic [15:0] cycles;

  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign reg_data = regs[addr];

  debug_pipeline_sequencer dut (
    .i_clock           (clk),
    .i_soft_reset      (rst_n),
    .i_cmd_valid       (cmd_valid),
    .i_cmd             (cmd),
    .o_cmd_ready       (cmd_ready),
    .i_halt_detected   (halt),
    .o_enable_pipeline (en_pipe),
    .o_enable_etapa    (etapa),
    .o_reg_read_addr   (addr),
    .i_reg_data        (reg_data),
    .o_dump_valid      (dump_valid),
    .o_dump_data       (dump_data),
    .i_dump_ready      (dump_ready),
    .o_halted          (halted),
    .o_cycle_count     (cycles)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    cmd_valid = 1'b0; halt = 1'b0; dump_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic issue(input logic [1:0] c);
    cmd_valid = 1'b1; cmd = c;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({en_pipe, etapa, dump_valid, halted} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {en_pipe, etapa, dump_valid, halted});
    end
    checks++;
    if ({cycles, addr, dump_data} !== 53'd0) begin
      errors++; $display("FAIL reset_values: got cnt=%0h addr=%0h data=%0h expected 0", cycles, addr, dump_data);
    end
    apply_reset();
    checks++;
    if (cmd_ready !== 1'b1 || etapa !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got ready=%b etapa=%b expected 1/0", cmd_ready, etapa);
    end
  endtask

  task automatic test_step();
    int highs;
    apply_reset();
    issue(2'b01);
    highs = 0;
    checks++;
    if (en_pipe !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL step_active: got en=%b ready=%b expected 1/0", en_pipe, cmd_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (en_pipe === 1'b1) highs++;
      cycle();
    end
    checks++;
    if (highs !== 1) begin
      errors++; $display("FAIL step_one_cycle: got %0d enabled cycles expected 1", highs);
    end
    checks++;
    if (cycles !== 16'd1 || etapa !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL step_idle: got cnt=%0d etapa=%b ready=%b expected 1/0/1", cycles, etapa, cmd_ready);
    end
  endtask

  task automatic test_run_halt();
    apply_reset();
    issue(2'b00);
    repeat (9) cycle();
    checks++;
    if (cycles !== 16'd9 || en_pipe !== 1'b1) begin
      errors++; $display("FAIL run_count9: got cnt=%0d en=%b expected 9/1", cycles, en_pipe);
    end
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    checks++;
    if (cycles !== 16'd10 || halted !== 1'b1 || en_pipe !== 1'b0) begin
      errors++; $display("FAIL run_halt: got cnt=%0d halted=%b en=%b expected 10/1/0", cycles, halted, en_pipe);
    end
`ifdef DEBUG_SEQ_AUTO_DUMP_EN
    checks++;
    if (cmd_ready !== 1'b0 || dump_valid !== 1'b0) begin
      errors++; $display("FAIL halt_dest: got ready=%b valid=%b expected 0/0", cmd_ready, dump_valid);
    end
`else
    checks++;
    if (cmd_ready !== 1'b1 || etapa !== 1'b1) begin
      errors++; $display("FAIL halt_dest: got ready=%b etapa=%b expected 1/1", cmd_ready, etapa);
    end
`endif
    cycle();
    checks++;
    if (cycles !== 16'd10 || en_pipe !== 1'b0) begin
      errors++; $display("FAIL halt_frozen: got cnt=%0d en=%b expected 10/0", cycles, en_pipe);
    end
  endtask

  // Follows test_run_halt: dump all registers with a 3-cycle stall on beat 5.
  task automatic test_dump();
    int beat, stalls, cyc, en_bad;
    beat = 0; stalls = 0; cyc = 0; en_bad = 0;
`ifndef DEBUG_SEQ_AUTO_DUMP_EN
    issue(2'b10);
`endif
    while (beat < 32 && cyc < 500) begin
      if (en_pipe !== 1'b0) en_bad++;
      if (dump_valid === 1'b1) begin
        checks++;
        if (dump_data !== beat * 4 || addr !== beat[4:0]) begin
          errors++; $display("FAIL dump_beat%0d: got data=%0d addr=%0d expected %0d/%0d", beat, dump_data, addr, beat * 4, beat);
        end
        if (beat == 5 && stalls < 3) begin
          dump_ready = 1'b0;
          stalls++;
        end else begin
          dump_ready = 1'b1;
          beat++;
        end
      end else begin
        dump_ready = (beat == 5 && stalls < 3) ? 1'b0 : 1'b1;
      end
      cycle();
      cyc++;
    end
    dump_ready = 1'b0;
    checks++;
    if (beat !== 32) begin
      errors++; $display("FAIL dump_timeout: got %0d beats expected 32", beat);
    end
    checks++;
    if (en_bad !== 0) begin
      errors++; $display("FAIL dump_pipe_en: got %0d enabled cycles expected 0", en_bad);
    end
    checks++;
`ifdef DEBUG_SEQ_AUTO_DUMP_EN
    if (cyc !== 66) begin
`else
    if (cyc !== 67) begin
`endif
      errors++; $display("FAIL dump_length: got %0d cycles expected 2*32+3 from entry", cyc);
    end
    checks++;
    if (dump_valid !== 1'b0 || halted !== 1'b1 || cmd_ready !== 1'b1 || addr !== 5'd0 || cycles !== 16'd10) begin
      errors++; $display("FAIL dump_end: got valid=%b halted=%b ready=%b addr=%0d cnt=%0d expected 0/1/1/0/10",
                         dump_valid, halted, cmd_ready, addr, cycles);
    end
    issue(2'b11);
    checks++;
    if (halted !== 1'b0 || etapa !== 1'b0) begin
      errors++; $display("FAIL halted_abort: got halted=%b etapa=%b expected 0/0", halted, etapa);
    end
  endtask

  task automatic test_abort_halt();
    apply_reset();
    issue(2'b00);
    issue(2'b01);
    issue(2'b10);
    checks++;
    if (en_pipe !== 1'b1 || cycles !== 16'd2) begin
      errors++; $display("FAIL run_drops_cmds: got en=%b cnt=%0d expected 1/2", en_pipe, cycles);
    end
    cmd_valid = 1'b1; cmd = 2'b11; halt = 1'b1;
    cycle();
    cmd_valid = 1'b0; halt = 1'b0;
    checks++;
    if (halted !== 1'b1 || etapa !== 1'b1 || en_pipe !== 1'b0) begin
      errors++; $display("FAIL abort_halt: got halted=%b etapa=%b en=%b expected 1/1/0", halted, etapa, en_pipe);
    end
`ifdef DEBUG_SEQ_AUTO_DUMP_EN
    cycle();
    checks++;
    if (dump_valid !== 1'b1 || dump_data !== 32'd0) begin
      errors++; $display("FAIL abort_halt_dump: got valid=%b data=%0d expected 1/0", dump_valid, dump_data);
    end
`else
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL abort_halt_state: got ready=%b expected 1", cmd_ready);
    end
`endif
  endtask

  task automatic test_reset_during_dump();
    int beat, cyc;
    apply_reset();
    issue(2'b10);
    dump_ready = 1'b1;
    beat = 0; cyc = 0;
    while (cyc < 200) begin
      if (dump_valid === 1'b1) begin
        if (beat == 7) break;
        beat++;
      end
      cycle();
      cyc++;
    end
    checks++;
    if (beat !== 7 || dump_data !== 32'd28) begin
      errors++; $display("FAIL rst_dump_beat7: got beat=%0d data=%0d expected 7/28", beat, dump_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dump_valid, etapa, en_pipe, halted} !== 4'b0000 || addr !== 5'd0 || dump_data !== 32'd0) begin
      errors++; $display("FAIL rst_async: got valid=%b etapa=%b addr=%0d data=%0d expected all 0",
                         dump_valid, etapa, addr, dump_data);
    end
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (dump_valid !== 1'b0) begin
        errors++; $display("FAIL rst_no_valid: got valid=%b at cycle %0d expected 0", dump_valid, i);
      end
    end
    issue(2'b10);
    checks++;
    if (addr !== 5'd0) begin
      errors++; $display("FAIL redump_addr: got %0d expected 0", addr);
    end
    cycle();
    checks++;
    if (dump_valid !== 1'b1 || dump_data !== 32'd0) begin
      errors++; $display("FAIL redump_beat0: got valid=%b data=%0d expected 1/0", dump_valid, dump_data);
    end
    dump_ready = 1'b0;
  endtask

  task automatic test_saturate();
    apply_reset();
    issue(2'b00);
    repeat (65534) cycle();
    checks++;
    if (cycles !== 16'hFFFE) begin
      errors++; $display("FAIL sat_pre: got %0h expected fffe", cycles);
    end
    repeat (70000 - 65534) cycle();
    checks++;
    if (cycles !== 16'hFFFF || en_pipe !== 1'b1) begin
      errors++; $display("FAIL sat_hold: got cnt=%0h en=%b expected ffff/1", cycles, en_pipe);
    end
    issue(2'b11);
    checks++;
    if (cycles !== 16'hFFFF || en_pipe !== 1'b0 || etapa !== 1'b0) begin
      errors++; $display("FAIL sat_abort: got cnt=%0h en=%b etapa=%b expected ffff/0/0", cycles, en_pipe, etapa);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 4);
    test_reset();
    test_step();
    test_run_halt();
    test_dump();
    test_abort_halt();
    test_reset_during_dump();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
